// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST sequencer.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StDone
  } bist_state_e;

  // Feedback tap paired with the MSB: x^20+x^17+1 -> l[19]^l[16], x^10+x^7+1 -> m[9]^m[6].
  localparam int unsigned LfsrTap = 16;
  localparam int unsigned MisrTap = 6;

  localparam int unsigned DefNIn    = 20;
  localparam int unsigned DefNOut   = 10;
  localparam int unsigned DefSettle = 2;
  localparam int unsigned DefCntW   = 16;

  // Settle counter width; SETTLE is limited to 0..15.
  localparam int unsigned SettleW = 4;

endpackage

// File: rtl/bist_shift_reg.sv
// Left-shifting feedback register: bit 0 takes q[MSB]^q[Tap].
// With ParEn set, a parallel word is XORed in on each shift (MISR mode).
module bist_shift_reg #(
  parameter int unsigned Width = 10,
  parameter int unsigned Tap   = 6,
  parameter bit          ParEn = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  input  logic [Width-1:0] par_in,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q, q_d, shifted;

  // Next value: load has priority over a shift step.
  always_comb begin
    shifted = {q_q[Width-2:0], q_q[Width-1] ^ q_q[Tap]};
    if (ParEn) begin
      shifted = shifted ^ par_in;
    end
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = shifted;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gate_model_bist_ctrl.sv
// BIST sequencer: LFSR patterns held SETTLE+1 cycles, responses folded into a MISR,
// signature compared to a latched golden value at the end of the run.
module gate_model_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned N_IN   = DefNIn,
  parameter int unsigned N_OUT  = DefNOut,
  parameter int unsigned SETTLE = DefSettle,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [N_OUT-1:0] expected,
  output logic [N_IN-1:0]  pat_out,
  input  logic [N_OUT-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature,
  output logic [CNT_W-1:0] pat_cnt
);

  bist_state_e        state_q, state_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [N_OUT-1:0]   exp_q, exp_d;

  logic            lfsr_load, lfsr_en, misr_load, misr_en;
  logic [N_IN-1:0] seed_eff;
  logic            hold_last;

  // A zero seed would lock the LFSR at zero.
  assign seed_eff  = (seed == '0) ? N_IN'(1) : seed;
  assign hold_last = (settle_q == SettleW'(SETTLE));
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Next-state logic and datapath strobes; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    exp_d     = exp_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            lfsr_load = 1'b1;
            misr_load = 1'b1;
            cnt_d     = '0;
            settle_d  = '0;
            num_d     = num_patterns;
            exp_d     = expected;
            state_d   = (num_patterns == '0) ? StDone : StApply;
          end
        end
        StApply: begin
          if (hold_last) begin
            settle_d = '0;
            misr_en  = 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_inc == num_q) begin
              // Keep the last applied pattern on pat_out while in DONE.
              state_d = StDone;
            end else begin
              lfsr_en = 1'b1;
            end
          end else begin
            settle_d = settle_q + SettleW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      exp_q    <= exp_d;
    end
  end

  bist_shift_reg #(
    .Width(N_IN),
    .Tap  (LfsrTap),
    .ParEn(1'b0)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .load_val(seed_eff),
    .en      (lfsr_en),
    .par_in  ('0),
    .q       (pat_out)
  );

  bist_shift_reg #(
    .Width(N_OUT),
    .Tap  (MisrTap),
    .ParEn(1'b1)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (misr_load),
    .load_val('0),
    .en      (misr_en),
    .par_in  (resp_in),
    .q       (signature)
  );

  assign busy    = (state_q == StApply);
  assign done    = (state_q == StDone);
  assign pass    = done && (signature == exp_q);
  assign pat_cnt = cnt_q;

endmodule

// File: tb/tb_gate_model_bist_ctrl.sv
// Bench for gate_model_bist_ctrl: two instances (SETTLE=2 and SETTLE=0) share stimulus,
// each driven by a toy gate model, checked against a polynomial reference model.
module tb_gate_model_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [19:0] seed = '0;
  logic [15:0] num_patterns = '0;
  logic [9:0]  expected = '0;
  logic        force_resp = 1'b0;
  logic [9:0]  force_val = '0;

  logic [19:0] pat2, pat0;
  logic [9:0]  resp2, resp0, sig2, sig0;
  logic        busy2, busy0, done2, done0, pass2, pass0;
  logic [15:0] cnt2, cnt0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Toy combinational gate model feeding resp_in.
  function automatic logic [9:0] gm(input logic [19:0] p);
    return p[9:0] ^ p[19:10] ^ {p[4:0], p[19:15]} ^ 10'h2A5;
  endfunction

  assign resp2 = force_resp ? force_val : gm(pat2);
  assign resp0 = force_resp ? force_val : gm(pat0);

  gate_model_bist_ctrl #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .num_patterns(num_patterns), .expected(expected), .pat_out(pat2), .resp_in(resp2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pat_cnt(cnt2)
  );

  gate_model_bist_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .num_patterns(num_patterns), .expected(expected), .pat_out(pat0), .resp_in(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .pat_cnt(cnt0)
  );

  // Reference: multiply by x modulo the polynomial, arithmetic form.
  function automatic logic [19:0] lfsr_next(input logic [19:0] l);
    int unsigned v, fb;
    v  = l;
    fb = ((v >> 19) ^ (v >> 16)) & 1;
    return 20'(((v * 2) % 32'h100000) + fb);
  endfunction

  function automatic logic [9:0] misr_next(input logic [9:0] m, input logic [9:0] r);
    int unsigned v, fb;
    v  = m;
    fb = ((v >> 9) ^ (v >> 6)) & 1;
    return 10'(((v * 2) % 1024) + fb) ^ r;
  endfunction

  function automatic logic [19:0] model_pat(input logic [19:0] s, input int idx);
    logic [19:0] l;
    l = (s == 0) ? 20'd1 : s;
    for (int i = 0; i < idx; i++) l = lfsr_next(l);
    return l;
  endfunction

  function automatic logic [9:0] model_sig(input logic [19:0] s, input int n);
    logic [19:0] l;
    logic [9:0]  m;
    l = (s == 0) ? 20'd1 : s;
    m = '0;
    for (int i = 0; i < n; i++) begin
      m = misr_next(m, gm(l));
      l = lfsr_next(l);
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for both instances to leave APPLY.
  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((busy2 || busy0) && c < 500) begin
      tick();
      c++;
    end
    n_checks++;
    if (busy2 || busy0) begin
      n_fail++;
      $display("FAIL %s timeout: busy2=%0b busy0=%0b after %0d cycles, required idle", name,
               busy2, busy0, c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({pat2, busy2, done2, pass2, sig2, cnt2} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut2: got %h required 0", {pat2, busy2, done2, pass2, sig2, cnt2});
    end
    n_checks++;
    if ({pat0, busy0, done0, pass0, sig0, cnt0} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut0: got %h required 0", {pat0, busy0, done0, pass0, sig0, cnt0});
    end
    rst_n = 1'b1;
    tick();
    seed = 20'h12345;
    num_patterns = 16'd10;
    expected = 10'h000;
    pulse_start();
    repeat (6) tick();
    n_checks++;
    if (busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun_busy: got %b required 1", busy2);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pat2, busy2, done2, pass2, sig2, cnt2} !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun_dut2: got %h required 0", {pat2, busy2, done2, pass2, sig2, cnt2});
    end
    n_checks++;
    if ({pat0, busy0, done0, pass0, sig0, cnt0} !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun_dut0: got %h required 0", {pat0, busy0, done0, pass0, sig0, cnt0});
    end
    #3;
    rst_n = 1'b1;
    tick();
    expected = model_sig(seed, 10);
    pulse_start();
    wait_idle("reset_rerun");
    n_checks++;
    if (sig2 !== model_sig(seed, 10) || pass2 !== 1'b1 || cnt2 !== 16'd10) begin
      n_fail++;
      $display("FAIL reset_rerun: sig=%h pass=%b cnt=%0d required sig=%h pass=1 cnt=10",
               sig2, pass2, cnt2, model_sig(seed, 10));
    end
  endtask

  task automatic test_lfsr();
    logic [19:0] want [3];
    want[0] = 20'h00001;
    want[1] = 20'h00002;
    want[2] = 20'h00004;
    seed = 20'h00001;
    num_patterns = 16'd5;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pat0 !== want[i]) begin
        n_fail++;
        $display("FAIL lfsr_step%0d: got %h required %h", i, pat0, want[i]);
      end
      tick();
    end
    wait_idle("lfsr");
  endtask

  task automatic test_zero_seed();
    seed = 20'h0;
    num_patterns = 16'd2;
    pulse_start();
    n_checks++;
    if (pat0 !== 20'h00001 || pat2 !== 20'h00001) begin
      n_fail++;
      $display("FAIL zero_seed: got %h/%h required 00001", pat0, pat2);
    end
    wait_idle("zero_seed");
  endtask

  task automatic test_misr();
    force_resp = 1'b1;
    force_val = 10'h3FF;
    seed = 20'(($urandom() % 32'hFFFFF) + 1);
    num_patterns = 16'd3;
    expected = 10'h3FD;
    pulse_start();
    wait_idle("misr_a");
    n_checks++;
    if (sig2 !== 10'h3FD || done2 !== 1'b1 || pass2 !== 1'b1) begin
      n_fail++;
      $display("FAIL misr_pass_dut2: sig=%h done=%b pass=%b required 3fd 1 1", sig2, done2, pass2);
    end
    n_checks++;
    if (sig0 !== 10'h3FD || done0 !== 1'b1 || pass0 !== 1'b1) begin
      n_fail++;
      $display("FAIL misr_pass_dut0: sig=%h done=%b pass=%b required 3fd 1 1", sig0, done0, pass0);
    end
    expected = 10'h3FC;
    pulse_start();
    wait_idle("misr_b");
    n_checks++;
    if (sig2 !== 10'h3FD || done2 !== 1'b1 || pass2 !== 1'b0) begin
      n_fail++;
      $display("FAIL misr_fail_case: sig=%h done=%b pass=%b required 3fd 1 0", sig2, done2, pass2);
    end
    force_resp = 1'b0;
  endtask

  task automatic test_settle();
    logic [19:0] seen [$];
    int c;
    seed = 20'(($urandom() % 32'hFFFFF) + 1);
    num_patterns = 16'd4;
    expected = model_sig(seed, 4);
    pulse_start();
    c = 0;
    while (busy2 && c < 100) begin
      seen.push_back(pat2);
      c++;
      tick();
    end
    n_checks++;
    if (c !== 12) begin
      n_fail++;
      $display("FAIL settle_busy_len: got %0d cycles required 12", c);
    end
    for (int i = 0; i < seen.size() && i < 12; i++) begin
      n_checks++;
      if (seen[i] !== model_pat(seed, i / 3)) begin
        n_fail++;
        $display("FAIL settle_hold cycle %0d: got %h required %h", i, seen[i], model_pat(seed, i / 3));
      end
    end
    n_checks++;
    if (done2 !== 1'b1 || pass2 !== 1'b1 || cnt2 !== 16'd4 || pat2 !== model_pat(seed, 3)) begin
      n_fail++;
      $display("FAIL settle_done: done=%b pass=%b cnt=%0d pat=%h required 1 1 4 %h",
               done2, pass2, cnt2, pat2, model_pat(seed, 3));
    end
    wait_idle("settle");
  endtask

  task automatic test_zero_patterns();
    num_patterns = 16'd0;
    expected = 10'h000;
    seed = 20'hABCDE;
    pulse_start();
    n_checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || pass2 !== 1'b1 || sig2 !== 10'h0 || cnt2 !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_pat: done=%b busy=%b pass=%b sig=%h cnt=%0d required 1 0 1 0 0",
               done2, busy2, pass2, sig2, cnt2);
    end
    expected = 10'h005;
    pulse_start();
    n_checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pat_nonzero_exp: done=%b pass=%b required 1 0", done0, pass0);
    end
  endtask

  task automatic test_start_busy();
    logic [19:0] s1;
    s1 = 20'(($urandom() % 32'hFFFFF) + 1);
    seed = s1;
    num_patterns = 16'd6;
    expected = model_sig(s1, 6);
    pulse_start();
    repeat (4) tick();
    seed = s1 ^ 20'h5A5A5;
    num_patterns = 16'd1;
    expected = 10'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("start_busy");
    n_checks++;
    if (sig2 !== model_sig(s1, 6) || cnt2 !== 16'd6 || pass2 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: sig=%h cnt=%0d pass=%b required %h 6 1",
               sig2, cnt2, pass2, model_sig(s1, 6));
    end
  endtask

  task automatic test_abort();
    int c;
    seed = 20'(($urandom() % 32'hFFFFF) + 1);
    num_patterns = 16'd8;
    expected = model_sig(seed, 2);
    pulse_start();
    c = 0;
    while (cnt2 !== 16'd2 && c < 100) begin
      tick();
      c++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || pass2 !== 1'b0 || cnt2 !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b pass=%b cnt=%0d required 0 0 0 2",
               busy2, done2, pass2, cnt2);
    end
    n_checks++;
    if (sig2 !== model_sig(seed, 2)) begin
      n_fail++;
      $display("FAIL abort_sig: got %h required %h", sig2, model_sig(seed, 2));
    end
    tick();
    n_checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stays_idle: busy=%b done=%b required 0 0", busy2, done2);
    end
  endtask

  task automatic test_start_abort();
    seed = 20'h00777;
    num_patterns = 16'd1;
    pulse_start();
    wait_idle("start_abort_pre");
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort: busy=%b/%b done=%b/%b required all 0", busy2, busy0, done2, done0);
    end
  endtask

  task automatic test_random();
    int n, c2, c0;
    logic [9:0] want;
    for (int r = 0; r < 10; r++) begin
      seed = 20'($urandom());
      n = $urandom_range(1, 25);
      num_patterns = 16'(n);
      want = model_sig(seed, n);
      expected = ($urandom() % 2 == 0) ? want : 10'($urandom());
      pulse_start();
      c2 = 0;
      c0 = 0;
      for (int k = 0; k < 200; k++) begin
        if (!busy2 && !busy0) break;
        if (busy2) c2++;
        if (busy0) c0++;
        tick();
      end
      n_checks++;
      if (c2 !== 3 * n || c0 !== n) begin
        n_fail++;
        $display("FAIL rand%0d_busy_len: got %0d/%0d required %0d/%0d", r, c2, c0, 3 * n, n);
      end
      n_checks++;
      if (sig2 !== want || sig0 !== want) begin
        n_fail++;
        $display("FAIL rand%0d_sig: got %h/%h required %h", r, sig2, sig0, want);
      end
      n_checks++;
      if (done2 !== 1'b1 || pass2 !== (want == expected) || pass0 !== (want == expected)) begin
        n_fail++;
        $display("FAIL rand%0d_pass: done=%b pass=%b/%b required 1 %b", r, done2, pass2, pass0,
                 want == expected);
      end
      n_checks++;
      if (cnt2 !== 16'(n) || pat2 !== model_pat(seed, n - 1) || pat0 !== model_pat(seed, n - 1)) begin
        n_fail++;
        $display("FAIL rand%0d_end: cnt=%0d pat=%h/%h required %0d %h", r, cnt2, pat2, pat0, n,
                 model_pat(seed, n - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_zero_seed();
    test_misr();
    test_settle();
    test_zero_patterns();
    test_start_busy();
    test_abort();
    test_start_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
